info_frame_packet_builder: RTL and testbench

Run-time programmable HDMI InfoFrame source. It replaces fixed, parameter-only InfoFrame modules. Software or control logic writes type, version, length and payload bytes into a shadow buffer; a sequential engine computes the checksum. The committed packet is swapped into the active header/subpacket outputs only at a packet-scheduler boundary. The block sits between the control/register logic and the HDMI packet picker, one instance per InfoFrame slot.

---
 rtl/info_frame_packet_builder.sv | 194 +++++++++++++++++++
 tb/tb_info_frame_packet_builder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/info_frame_packet_builder.sv
// Run-time programmable HDMI InfoFrame source: shadow payload/config, sequential
// checksum engine and a boundary-synchronised swap into the active packet outputs.
module info_frame_packet_builder #(
    parameter int         MAX_LENGTH      = 27,
    parameter logic [6:0] DEFAULT_TYPE    = 7'd2,
    parameter logic [7:0] DEFAULT_VERSION = 8'd2,
    parameter logic [4:0] DEFAULT_LENGTH  = 5'd13
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic [6:0]  cfg_type,
    input  logic [7:0]  cfg_version,
    input  logic [4:0]  cfg_length,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic        commit,
    input  logic        packet_boundary,
    output logic        busy,
    output logic        active_valid,
    output logic [23:0] header,
    output logic [55:0] sub [3:0]
);

    localparam logic [4:0] MAX_LEN_C = 5'(MAX_LENGTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SUM     = 2'd1,
        ST_PENDING = 2'd2,
        ST_SWAP    = 2'd3
    } state_t;

    // InfoFrame checksum byte: makes header + payload + checksum sum to zero.
    function automatic logic [7:0] info_checksum(input logic [7:0] acc);
        return 8'h00 - acc;
    endfunction

    state_t      state_q, state_d;
    logic        auto_q, auto_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  acc_q, acc_d;
    logic [6:0]  type_q, type_d;
    logic [7:0]  version_q, version_d;
    logic [4:0]  length_q, length_d;
    logic [7:0]  pb_q [0:27];
    logic [7:0]  pb_d [0:27];
    logic [23:0] header_q, header_d;
    logic [55:0] sub_q [3:0];
    logic [55:0] sub_d [3:0];
    logic        valid_q, valid_d;
    logic        wr_ready_q, wr_ready_d;
    logic        busy_q, busy_d;
    logic [7:0]  sum_byte;
    logic [4:0]  pb_idx;

    // State, shadow and active-packet registers with synchronous reset.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q    <= ST_SUM;
            auto_q     <= 1'b1;
            cnt_q      <= 5'd0;
            acc_q      <= 8'h00;
            type_q     <= DEFAULT_TYPE;
            version_q  <= DEFAULT_VERSION;
            length_q   <= DEFAULT_LENGTH;
            for (int k = 0; k < 28; k++) begin
                pb_q[k] <= 8'h00;
            end
            header_q   <= 24'h000000;
            for (int i = 0; i < 4; i++) begin
                sub_q[i] <= 56'h0;
            end
            valid_q    <= 1'b0;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            auto_q     <= auto_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            type_q     <= type_d;
            version_q  <= version_d;
            length_q   <= length_d;
            pb_q       <= pb_d;
            header_q   <= header_d;
            sub_q      <= sub_d;
            valid_q    <= valid_d;
            wr_ready_q <= wr_ready_d;
            busy_q     <= busy_d;
        end
    end

    // Byte fed to the accumulator: header bytes 2,1,0 then PB1..PBL.
    always_comb begin
        sum_byte = 8'h00;
        pb_idx   = cnt_q - 5'd2;
        case (cnt_q)
            5'd0:    sum_byte = {3'b000, length_q};
            5'd1:    sum_byte = version_q;
            5'd2:    sum_byte = {1'b1, type_q};
            default: begin
                if (pb_idx <= 5'd27) begin
                    sum_byte = pb_q[pb_idx];
                end else begin
                    sum_byte = 8'h00;
                end
            end
        endcase
    end

    // Next-state logic, shadow writes, checksum accumulation and packet swap.
    always_comb begin
        state_d   = state_q;
        auto_d    = auto_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        type_d    = type_q;
        version_d = version_q;
        length_d  = length_q;
        pb_d      = pb_q;
        header_d  = header_q;
        sub_d     = sub_q;
        valid_d   = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (wr_en && (wr_addr >= 5'd1) && (wr_addr <= 5'd27)) begin
                    pb_d[wr_addr] = wr_data;
                end else begin
                    pb_d = pb_q;
                end
                if (commit) begin
                    type_d    = cfg_type;
                    version_d = cfg_version;
                    length_d  = (cfg_length > MAX_LEN_C) ? MAX_LEN_C : cfg_length;
                    acc_d     = 8'h00;
                    cnt_d     = 5'd0;
                    state_d   = ST_SUM;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SUM: begin
                acc_d = acc_q + sum_byte;
                if (cnt_q == (length_q + 5'd2)) begin
                    cnt_d   = 5'd0;
                    state_d = auto_q ? ST_SWAP : ST_PENDING;
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                end
            end
            ST_PENDING: begin
                if (packet_boundary) begin
                    state_d = ST_SWAP;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            ST_SWAP: begin
                header_d = {3'b000, length_q, version_q, 1'b1, type_q};
                // Bytes beyond the committed length go out as zero even if the shadow holds data.
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 7; j++) begin
                        if ((7 * i + j) == 0) begin
                            sub_d[i][8*j +: 8] = info_checksum(acc_q);
                        end else if ((7 * i + j) <= int'(length_q)) begin
                            sub_d[i][8*j +: 8] = pb_q[7 * i + j];
                        end else begin
                            sub_d[i][8*j +: 8] = 8'h00;
                        end
                    end
                end
                valid_d = 1'b1;
                auto_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d == ST_SUM) || (state_d == ST_PENDING);
    end

    assign wr_ready     = wr_ready_q;
    assign busy         = busy_q;
    assign active_valid = valid_q;
    assign header       = header_q;
    assign sub          = sub_q;

endmodule

// File: tb/tb_info_frame_packet_builder.sv
// Directed self-checking bench for info_frame_packet_builder.
module tb_info_frame_packet_builder;

    logic        clk_pixel;
    logic        reset;
    logic [6:0]  cfg_type;
    logic [7:0]  cfg_version;
    logic [4:0]  cfg_length;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        commit;
    logic        packet_boundary;
    logic        busy;
    logic        active_valid;
    logic [23:0] header;
    logic [55:0] sub [3:0];

    int vec_cnt;
    int err_cnt;

    info_frame_packet_builder dut (
        .clk_pixel       (clk_pixel),
        .reset           (reset),
        .cfg_type        (cfg_type),
        .cfg_version     (cfg_version),
        .cfg_length      (cfg_length),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_ready        (wr_ready),
        .commit          (commit),
        .packet_boundary (packet_boundary),
        .busy            (busy),
        .active_valid    (active_valid),
        .header          (header),
        .sub             (sub)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    task automatic cycle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk_pixel);
            #1;
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cycle(1);
        wr_en = 1'b0;
    endtask

    task automatic do_commit(input logic [6:0] t, input logic [7:0] v, input logic [4:0] l);
        cfg_type = t; cfg_version = v; cfg_length = l; commit = 1'b1;
        cycle(1);
        commit = 1'b0;
    endtask

    task automatic pulse_boundary();
        packet_boundary = 1'b1;
        cycle(1);
        packet_boundary = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle(3);
        vec_cnt++;
        if (active_valid !== 1'b0 || header !== 24'h0 || sub[0] !== 56'h0) begin
            err_cnt++;
            $display("FAIL reset_outputs: valid=%b header=%h sub0=%h, want 0/0/0", active_valid, header, sub[0]);
        end
        vec_cnt++;
        if (busy !== 1'b1 || wr_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_busy: busy=%b wr_ready=%b, want 1/0", busy, wr_ready);
        end
        reset = 1'b0;
        cycle(16);
        vec_cnt++;
        if (active_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL auto_not_early: valid=%b after 16 cycles, want 0", active_valid);
        end
        cycle(1);
        vec_cnt++;
        if (active_valid !== 1'b1 || header !== 24'h0D0282 || sub[0] !== 56'h6F) begin
            err_cnt++;
            $display("FAIL auto_build: valid=%b header=%h sub0=%h, want 1/0d0282/6f", active_valid, header, sub[0]);
        end
        vec_cnt++;
        if (sub[1] !== 56'h0 || sub[2] !== 56'h0 || sub[3] !== 56'h0) begin
            err_cnt++;
            $display("FAIL auto_zero: sub1=%h sub2=%h sub3=%h, want 0", sub[1], sub[2], sub[3]);
        end
        vec_cnt++;
        if (wr_ready !== 1'b1 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL auto_idle: wr_ready=%b busy=%b, want 1/0", wr_ready, busy);
        end
        cycle(3);
    endtask

    task automatic test_avi();
        do_write(5'd2, 8'h08);
        // write and commit in the same cycle: the write must enter the sum
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 8'h01;
        do_commit(7'd2, 8'd2, 5'd13);
        wr_en = 1'b0;
        vec_cnt++;
        if (busy !== 1'b1 || wr_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL avi_busy: busy=%b wr_ready=%b, want 1/0", busy, wr_ready);
        end
        cycle(21);
        vec_cnt++;
        if (busy !== 1'b1 || sub[0] !== 56'h6F) begin
            err_cnt++;
            $display("FAIL avi_pending_hold: busy=%b sub0=%h, want 1/6f", busy, sub[0]);
        end
        pulse_boundary();
        vec_cnt++;
        if (sub[0] !== 56'h6F) begin
            err_cnt++;
            $display("FAIL avi_swap_timing: sub0=%h one edge after boundary, want 6f", sub[0]);
        end
        cycle(1);
        vec_cnt++;
        if (sub[0] !== 56'h00_00_01_00_08_00_66 || header !== 24'h0D0282) begin
            err_cnt++;
            $display("FAIL avi_packet: sub0=%h header=%h, want 00000100080066/0d0282", sub[0], header);
        end
        cycle(1);
    endtask

    task automatic test_audio();
        reset = 1'b1;
        cycle(2);
        reset = 1'b0;
        cycle(18);
        do_write(5'd1, 8'h01);
        do_commit(7'd4, 8'd1, 5'd10);
        cycle(16);
        pulse_boundary();
        cycle(1);
        vec_cnt++;
        if (header !== 24'h0A0184) begin
            err_cnt++;
            $display("FAIL audio_header: header=%h, want 0a0184", header);
        end
        vec_cnt++;
        if (sub[0] !== 56'h00_00_00_00_00_01_70) begin
            err_cnt++;
            $display("FAIL audio_sub0: sub0=%h, want 00000000000170", sub[0]);
        end
        cycle(1);
    endtask

    task automatic test_pending();
        do_commit(7'd3, 8'd1, 5'd5);
        // boundary while still summing must be ignored
        packet_boundary = 1'b1;
        cycle(2);
        packet_boundary = 1'b0;
        cycle(8);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 8'h55;
        do_commit(7'd6, 8'd3, 5'd20);
        wr_en = 1'b0;
        cycle(3);
        vec_cnt++;
        if (header !== 24'h0A0184 || sub[0] !== 56'h00_00_00_00_00_01_70 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL pend_hold: header=%h sub0=%h busy=%b, want 0a0184/..0170/1", header, sub[0], busy);
        end
        pulse_boundary();
        vec_cnt++;
        if (header !== 24'h0A0184) begin
            err_cnt++;
            $display("FAIL pend_timing: header=%h one edge after boundary, want 0a0184", header);
        end
        cycle(1);
        vec_cnt++;
        if (header !== 24'h050183 || sub[0] !== 56'h00_00_00_00_00_01_76) begin
            err_cnt++;
            $display("FAIL pend_packet: header=%h sub0=%h, want 050183/00000000000176", header, sub[0]);
        end
        cycle(1);
    endtask

    task automatic test_clamp();
        do_write(5'd20, 8'hAA);
        do_commit(7'd2, 8'd2, 5'd5);
        cycle(10);
        pulse_boundary();
        cycle(1);
        vec_cnt++;
        if (header !== 24'h050282 || sub[0] !== 56'h00_00_00_00_00_01_76 || sub[2] !== 56'h0) begin
            err_cnt++;
            $display("FAIL short_len: header=%h sub0=%h sub2=%h, want 050282/..0176/0", header, sub[0], sub[2]);
        end
        cycle(1);
        do_commit(7'd2, 8'd2, 5'd31);
        cycle(32);
        pulse_boundary();
        cycle(1);
        vec_cnt++;
        if (header !== 24'h1B0282) begin
            err_cnt++;
            $display("FAIL clamp_header: header=%h, want 1b0282", header);
        end
        vec_cnt++;
        if (sub[2] !== 56'hAA_00_00_00_00_00_00 || sub[0] !== 56'h00_00_00_00_00_01_B6 || sub[3] !== 56'h0) begin
            err_cnt++;
            $display("FAIL clamp_payload: sub0=%h sub2=%h sub3=%h, want ..01b6/aa000000000000/0", sub[0], sub[2], sub[3]);
        end
        cycle(1);
    endtask

    task automatic test_reset_mid();
        do_commit(7'd4, 8'd1, 5'd10);
        cycle(4);
        reset = 1'b1;
        cycle(1);
        vec_cnt++;
        if (active_valid !== 1'b0 || header !== 24'h0 || sub[0] !== 56'h0 || sub[2] !== 56'h0) begin
            err_cnt++;
            $display("FAIL mid_reset: valid=%b header=%h sub0=%h sub2=%h, want zeros", active_valid, header, sub[0], sub[2]);
        end
        cycle(2);
        reset = 1'b0;
        cycle(17);
        vec_cnt++;
        if (active_valid !== 1'b1 || header !== 24'h0D0282 || sub[0] !== 56'h6F || sub[2] !== 56'h0) begin
            err_cnt++;
            $display("FAIL mid_reset_auto: valid=%b header=%h sub0=%h sub2=%h, want 1/0d0282/6f/0", active_valid, header, sub[0], sub[2]);
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        reset = 1'b1;
        cfg_type = 7'd0; cfg_version = 8'd0; cfg_length = 5'd0;
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = 8'h00;
        commit = 1'b0; packet_boundary = 1'b0;
        test_reset();
        test_avi();
        test_audio();
        test_pending();
        test_clamp();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
